// File: rtl/calc_pkg.sv
// Shared types for the calculator operand entry path: FSM states, operator codes, widths.
// No logic; no latency. No flow control.
// Imported by operand_entry_ctrl and nibble_pack.
package calc_pkg;

    localparam int NIBBLE_W  = 4;
    localparam int OPERAND_W = 2 * NIBBLE_W;
    localparam int OPCODE_W  = 2;

    typedef enum logic [2:0] {
        A_LO  = 3'd0,
        A_HI  = 3'd1,
        OP    = 3'd2,
        B_LO  = 3'd3,
        B_HI  = 3'd4,
        ISSUE = 3'd5
    } entry_state_t;

    typedef enum logic [OPCODE_W-1:0] {
        ADD = 2'd0,
        SUB = 2'd1,
        MUL = 2'd2,
        DIV = 2'd3
    } op_code_t;

    typedef logic [NIBBLE_W-1:0]  nibble_t;
    typedef logic [OPERAND_W-1:0] operand_t;

endpackage

// File: rtl/nibble_pack.sv
// Packs two entered digit nibbles into one operand byte, hi nibble on top.
// Latency: combinational.
// Backpressure: none.
module nibble_pack
    import calc_pkg::*;
(
    input  nibble_t  hi,
    input  nibble_t  lo,
    output operand_t dat
);

    assign dat = {hi, lo};

endmodule

// File: rtl/operand_entry_ctrl.sv
// Collects A(lo,hi), operator, B(lo,hi) from strobes and presents them to the ALU.
// Latency: out_valid one cycle after the B hi nibble; ENTRY_TIMEOUT_EN builds an idle-entry timeout.
// Backpressure: holds ISSUE with stable outputs until out_valid && out_ready.
module operand_entry_ctrl
    import calc_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000
)
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 nib_valid,
    input  logic [NIBBLE_W-1:0]  nib_data,
    input  logic                 op_valid,
    input  logic [OPCODE_W-1:0]  op_code,
    input  logic                 clear,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OPERAND_W-1:0] operand_a,
    output logic [OPERAND_W-1:0] operand_b,
    output logic [OPCODE_W-1:0]  out_op,
    output logic                 busy,
    output logic                 timeout
);

    entry_state_t state_q, state_d;
    nibble_t      a_lo_q, a_hi_q, b_lo_q, b_hi_q;
    op_code_t     op_q;
    logic         nib_take, op_take, zero_regs, tmo_fire;

`ifdef ENTRY_TIMEOUT_EN
    logic [15:0] tmo_cnt_q;
    logic        stalled;
    logic        timeout_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= A_LO;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        nib_take  = 1'b0;
        op_take   = 1'b0;
        zero_regs = 1'b0;
        tmo_fire  = 1'b0;
        unique case (state_q)
            A_LO:  if (nib_valid) begin nib_take = 1'b1; state_d = A_HI;  end
            A_HI:  if (nib_valid) begin nib_take = 1'b1; state_d = OP;    end
            OP:    if (op_valid)  begin op_take  = 1'b1; state_d = B_LO;  end
            B_LO:  if (nib_valid) begin nib_take = 1'b1; state_d = B_HI;  end
            B_HI:  if (nib_valid) begin nib_take = 1'b1; state_d = ISSUE; end
            ISSUE: if (out_ready) state_d = A_LO;
            default: state_d = A_LO;
        endcase
`ifdef ENTRY_TIMEOUT_EN
        // In the entry states the state only moves on an accepted strobe.
        stalled  = (state_q inside {A_HI, OP, B_LO, B_HI}) && (state_d == state_q);
        tmo_fire = stalled && (tmo_cnt_q == 16'(TIMEOUT_CYCLES - 1));
`endif
        if (tmo_fire || clear) begin
            state_d   = A_LO;
            nib_take  = 1'b0;
            op_take   = 1'b0;
            zero_regs = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_lo_q <= '0;
            a_hi_q <= '0;
            b_lo_q <= '0;
            b_hi_q <= '0;
            op_q   <= ADD;
        end else if (zero_regs) begin
            a_lo_q <= '0;
            a_hi_q <= '0;
            b_lo_q <= '0;
            b_hi_q <= '0;
            op_q   <= ADD;
        end else begin
            if (nib_take) begin
                case (state_q)
                    A_LO:    a_lo_q <= nib_data;
                    A_HI:    a_hi_q <= nib_data;
                    B_LO:    b_lo_q <= nib_data;
                    B_HI:    b_hi_q <= nib_data;
                    default: ;
                endcase
            end
            if (op_take) op_q <= op_code_t'(op_code);
        end
    end

`ifdef ENTRY_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q <= (stalled && !tmo_fire && !clear) ? tmo_cnt_q + 16'd1 : 16'd0;
            timeout_q <= tmo_fire && !clear;
        end
    end

    assign timeout = timeout_q;
`else
    logic [31:0] unused_timeout_cycles;
    assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
    assign timeout = 1'b0;
`endif

    nibble_pack u_pack_a (.hi(a_hi_q), .lo(a_lo_q), .dat(operand_a));
    nibble_pack u_pack_b (.hi(b_hi_q), .lo(b_lo_q), .dat(operand_b));

    assign out_valid = (state_q == ISSUE);
    assign busy      = (state_q != A_LO);
    assign out_op    = op_q;

endmodule

// File: tb/tb_operand_entry_ctrl.sv
// Self-checking bench for operand_entry_ctrl: directed table, corner sequences, randomized vs. model.
// Timeout corner is exercised when ENTRY_TIMEOUT_EN is defined (TIMEOUT_CYCLES fixed at 8 here).
module tb_operand_entry_ctrl;

    localparam int TMO = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       nib_valid, op_valid, clear, out_ready;
    logic [3:0] nib_data;
    logic [1:0] op_code;
    logic       out_valid, busy, timeout;
    logic [7:0] operand_a, operand_b;
    logic [1:0] out_op;

    int n_checks = 0;
    int n_err    = 0;

    operand_entry_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .nib_valid(nib_valid), .nib_data(nib_data),
        .op_valid(op_valid), .op_code(op_code),
        .clear(clear),
        .out_valid(out_valid), .out_ready(out_ready),
        .operand_a(operand_a), .operand_b(operand_b), .out_op(out_op),
        .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Reference: entry progress as a token count 0..5 (5 = waiting for the ALU).
    int         m_pos;
    int         m_idle;
    logic [3:0] m_nib [4];
    logic [1:0] m_op;
    bit         m_to;

    function automatic void model_reset();
        m_pos = 0; m_idle = 0; m_op = 0; m_to = 0;
        for (int i = 0; i < 4; i++) m_nib[i] = 0;
    endfunction

    function automatic void model_edge(bit nv, logic [3:0] nd, bit ov, logic [1:0] oc, bit clr, bit rdy);
        int  pre = m_pos;
        bit  acc = 0;
        m_to = 0;
        if (clr) begin
            model_reset();
            return;
        end
        if (pre == 5) begin
            if (rdy) begin m_pos = 0; acc = 1; end
        end else if (pre == 2) begin
            if (ov) begin m_op = oc; m_pos = 3; acc = 1; end
        end else if (nv) begin
            m_nib[(pre > 2) ? pre - 1 : pre] = nd;
            m_pos = pre + 1;
            acc = 1;
        end
`ifdef ENTRY_TIMEOUT_EN
        if (acc || pre == 0 || pre == 5) m_idle = 0;
        else begin
            m_idle++;
            if (m_idle >= TMO) begin
                model_reset();
                m_to = 1;
            end
        end
`endif
    endfunction

    function automatic logic [20:0] model_out();
        logic [7:0] a = 8'(m_nib[1] * 16 + m_nib[0]);
        logic [7:0] b = 8'(m_nib[3] * 16 + m_nib[2]);
        return {m_pos == 5, m_pos != 0, m_to, a, b, m_op};
    endfunction

    function automatic logic [20:0] dut_out();
        return {out_valid, busy, timeout, operand_a, operand_b, out_op};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; drives inputs, crosses one rising edge, returns at the next negedge.
    task automatic step(input bit nv, input logic [3:0] nd, input bit ov, input logic [1:0] oc,
                        input bit clr, input bit rdy);
        nib_valid = nv; nib_data = nd; op_valid = ov; op_code = oc; clear = clr; out_ready = rdy;
        @(posedge clk);
        model_edge(nv, nd, ov, oc, clr, rdy);
        @(negedge clk);
    endtask

    task automatic idle(input bit rdy);
        step(0, 4'h0, 0, 2'd0, 0, rdy);
    endtask

    typedef struct {
        logic       nv;
        logic [3:0] nd;
        logic       ov;
        logic [1:0] oc;
        logic       clr;
        logic       rdy;
        logic       e_valid;
        logic       e_busy;
        logic [7:0] e_a;
        logic [7:0] e_b;
        logic [1:0] e_op;
    } vec_t;

    vec_t tbl [15];

    initial begin
        //          nv nd    ov oc    clr   rdy   valid busy  a      b      op
        tbl[0]  = '{1'b0, 4'h0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 2'd0};
        tbl[1]  = '{1'b1, 4'h3, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h03, 8'h00, 2'd0};
        tbl[2]  = '{1'b1, 4'hA, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA3, 8'h00, 2'd0};
        tbl[3]  = '{1'b1, 4'h7, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA3, 8'h00, 2'd0};
        tbl[4]  = '{1'b1, 4'h9, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA3, 8'h00, 2'd1};
        tbl[5]  = '{1'b1, 4'h5, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA3, 8'h05, 2'd1};
        tbl[6]  = '{1'b1, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA3, 8'h05, 2'd1};
        tbl[7]  = '{1'b0, 4'h0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA3, 8'h05, 2'd1};
        tbl[8]  = '{1'b0, 4'h0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA3, 8'h05, 2'd1};
        tbl[9]  = '{1'b1, 4'h1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA1, 8'h05, 2'd1};
        tbl[10] = '{1'b1, 4'h2, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h21, 8'h05, 2'd1};
        tbl[11] = '{1'b0, 4'h0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 8'h21, 8'h05, 2'd2};
        tbl[12] = '{1'b1, 4'h4, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h21, 8'h04, 2'd2};
        tbl[13] = '{1'b1, 4'h6, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 2'd0};
        tbl[14] = '{1'b1, 4'hF, 1'b1, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 2'd0};

        rst_n = 1'b0;
        nib_valid = 0; nib_data = 0; op_valid = 0; op_code = 0; clear = 0; out_ready = 0;
        model_reset();
        #12;
        chk("reset_outputs", 32'(dut_out()), 32'(21'h0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table: basic entry, ignored strobes, handshake, clear priority.
        for (int i = 0; i < 15; i++) begin
            step(tbl[i].nv, tbl[i].nd, tbl[i].ov, tbl[i].oc, tbl[i].clr, tbl[i].rdy);
            chk($sformatf("table[%0d]", i), 32'(dut_out()),
                32'({tbl[i].e_valid, tbl[i].e_busy, 1'b0, tbl[i].e_a, tbl[i].e_b, tbl[i].e_op}));
        end

        // ALU backpressure: ISSUE held 10 cycles, handshake on the 11th.
        step(1, 4'h3, 0, 2'd0, 0, 0);
        step(1, 4'hA, 0, 2'd0, 0, 0);
        step(0, 4'h0, 1, 2'd1, 0, 0);
        step(1, 4'h5, 0, 2'd0, 0, 0);
        step(1, 4'h0, 0, 2'd0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("stall_issue[%0d]", i), 32'(dut_out()), 32'({3'b110, 8'hA3, 8'h05, 2'd1}));
            idle(0);
        end
        chk("stall_still_valid", 32'(out_valid), 32'd1);
        idle(1);
        chk("after_handshake", 32'(dut_out()), 32'({3'b000, 8'hA3, 8'h05, 2'd1}));

        // Abandoned entry stalled in OP.
        step(1, 4'h1, 0, 2'd0, 0, 0);
        step(1, 4'h2, 0, 2'd0, 0, 0);
`ifdef ENTRY_TIMEOUT_EN
        for (int i = 0; i < TMO - 1; i++) begin
            idle(0);
            chk($sformatf("pre_timeout[%0d]", i), 32'({busy, timeout}), 32'(2'b10));
        end
        idle(0);
        chk("timeout_fire", 32'(dut_out()), 32'({3'b001, 8'h00, 8'h00, 2'd0}));
        idle(0);
        chk("timeout_one_pulse", 32'({busy, timeout}), 32'(2'b00));
        step(1, 4'h3, 0, 2'd0, 0, 0);
        step(1, 4'hA, 0, 2'd0, 0, 0);
        step(0, 4'h0, 1, 2'd1, 0, 0);
        step(1, 4'h5, 0, 2'd0, 0, 0);
        step(1, 4'h0, 0, 2'd0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            idle(0);
            chk($sformatf("issue_no_timeout[%0d]", i), 32'({out_valid, timeout}), 32'(2'b10));
        end
        idle(1);
`else
        for (int i = 0; i < 20; i++) begin
            idle(0);
            chk($sformatf("no_timeout_build[%0d]", i), 32'({busy, timeout, operand_a}), 32'({2'b10, 8'h21}));
        end
        step(0, 4'h0, 0, 2'd0, 1, 0);
`endif

        // Randomized traffic against the token model; strobe density varies per block.
        for (int blk = 0; blk < 20; blk++) begin
            int dens = $urandom_range(1, 8);
            for (int c = 0; c < 100; c++) begin
                bit         nv  = ($urandom_range(0, 15) < dens);
                bit         ov  = ($urandom_range(0, 15) < dens);
                bit         clr = ($urandom_range(0, 47) == 0);
                bit         rdy = ($urandom_range(0, 3) == 0);
                logic [3:0] nd  = 4'($urandom_range(0, 15));
                logic [1:0] oc  = 2'($urandom_range(0, 3));
                step(nv, nd, ov, oc, clr, rdy);
                chk("random_vs_model", 32'(dut_out()), 32'(model_out()));
            end
        end

        // Asynchronous reset in the middle of ISSUE.
        step(0, 4'h0, 0, 2'd0, 1, 0);
        step(1, 4'h4, 0, 2'd0, 0, 0);
        step(1, 4'h2, 0, 2'd0, 0, 0);
        step(0, 4'h0, 1, 2'd3, 0, 0);
        step(1, 4'h6, 0, 2'd0, 0, 0);
        step(1, 4'h1, 0, 2'd0, 0, 0);
        chk("issue_before_reset", 32'(dut_out()), 32'({3'b110, 8'h24, 8'h16, 2'd3}));
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outputs", 32'(dut_out()), 32'(21'h0));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 4'h7, 0, 2'd0, 0, 0);
        chk("after_reset_entry", 32'(dut_out()), 32'(model_out()));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/operand_entry_ctrl.md
OPERAND_ENTRY_CTRL -- requirements
Module: operand_entry_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1000, idle cycles before an abandoned entry is discarded (range 2..65535).
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 nib_valid  in  1  one-cycle strobe, nib_data valid this cycle.
REQ-005 nib_data  in  4  entered digit nibble.
REQ-006 op_valid  in  1  one-cycle strobe, op_code valid this cycle.
REQ-007 op_code  in  2  operator select (all four codes legal).
REQ-008 clear  in  1  abort entry, synchronous, highest priority.
REQ-009 out_valid  out  1  operand pair and operator ready for ALU.
REQ-010 out_ready  in  1  ALU accepts; transfer when out_valid && out_ready.
REQ-011 operand_a  out  8  first operand, {hi nibble, lo nibble}.
REQ-012 operand_b  out  8  second operand, {hi nibble, lo nibble}.
REQ-013 out_op  out  2  latched operator.
REQ-014 busy  out  1  high in every state except A_LO.
REQ-015 timeout  out  1  one-cycle pulse when entry discarded by timeout.

Function
REQ-016 FSM states SHALL be A_LO, A_HI, OP, B_LO, B_HI, ISSUE; encoding in shared package.
REQ-017 A_LO: accepted nib_valid stores low nibble of A, -> A_HI.
REQ-018 A_HI: accepted nib_valid stores high nibble of A, -> OP.
REQ-019 OP: accepted op_valid latches op_code, -> B_LO; nib_valid ignored in OP.
REQ-020 B_LO/B_HI: store low/high nibble of B as for A; B_HI acceptance -> ISSUE.
REQ-021 op_valid outside OP and nib_valid in OP/ISSUE SHALL be ignored with no state change.
REQ-022 Simultaneous nib_valid and op_valid: only the strobe legal for current state is taken.
REQ-023 out_valid SHALL assert the cycle after the B_HI nibble is accepted (latency 1) and only in ISSUE.
REQ-024 In ISSUE, operand_a, operand_b, out_op SHALL stay stable until handshake; out_valid SHALL not drop without handshake except on clear/reset.
REQ-025 Handshake in ISSUE -> A_LO next cycle; out_valid low that cycle; nibble registers retain values.
REQ-026 out_ready while not in ISSUE SHALL have no effect.
REQ-027 clear in any state -> A_LO next cycle, out_valid low, nibble and op registers zeroed; clear overrides any coincident strobe or handshake.
REQ-028 Operands SHALL be formed by pure packing, no arithmetic: bits[3:0]=lo nibble, bits[7:4]=hi nibble.

Reset
REQ-029 rst_n low SHALL immediately force state A_LO, out_valid=0, operand_a=0, operand_b=0, out_op=0, busy=0, timeout=0, timeout counter=0.
REQ-030 Reset mid-entry or during ISSUE SHALL discard the pending transaction without handshake.

Configuration
REQ-031 With ENTRY_TIMEOUT_EN defined: counter clears on every accepted strobe and on state change, counts in A_HI, OP, B_LO, B_HI; reaching TIMEOUT_CYCLES -> A_LO, registers zeroed as for clear, timeout pulses one cycle; ISSUE never times out.
REQ-032 Without ENTRY_TIMEOUT_EN: no counter is built, timeout tied 0, entry waits indefinitely; TIMEOUT_CYCLES unused.

Structure
REQ-033 Shared package calc_pkg SHALL hold the FSM state typedef, op_code typedef/constants (ADD, SUB, MUL, DIV) and the 4-bit nibble / 8-bit operand width constants.
REQ-034 One sub-module, nibble_pack (two 4-bit in, 8-bit out, combinational), SHALL be instantiated once per operand.

Verification
REQ-035 Reset, nibbles 3,A, op 1, nibbles 5,0, out_ready=1 -> out_valid one cycle after last nibble, operand_a=0xA3, operand_b=0x05, out_op=1, then busy=0.
REQ-036 Same entry with out_ready low 10 cycles -> out_valid and outputs stable all 10 cycles, handshake on cycle 11, A_LO next.
REQ-037 op_valid in A_LO and nib_valid in OP, plus simultaneous nib_valid+op_valid in OP -> only op accepted, nibbles unchanged.
REQ-038 clear in B_HI coinciding with nib_valid -> A_LO, out_valid never asserts, operand registers 0.
REQ-039 ENTRY_TIMEOUT_EN, TIMEOUT_CYCLES=8: stall 8 cycles in OP -> timeout pulse once, state A_LO; stall in ISSUE 20 cycles -> no timeout.
REQ-040 rst_n asserted asynchronously mid-ISSUE -> out_valid falls without clock edge, all outputs 0.
